// File: rtl/sdb_pkg.sv
// rtl/sdb_pkg.sv - shared width default and one-bit adder cell for the sdb carry-select block
package sdb_pkg;

    localparam int SDB_DEFAULT_WIDTH = 8;

    // Returns {c_next, s} for one bit position.
    function automatic logic [1:0] sdb_cell(input logic p, input logic g, input logic c);
        return {g | (p & c), p ^ c};
    endfunction

endpackage

// File: rtl/sdb_chain.sv
// rtl/sdb_chain.sv - combinational ripple chain of sdb_cell over WIDTH bits
module sdb_chain
    import sdb_pkg::*;
#(
    parameter int WIDTH = SDB_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] g,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] c;

    // The carry vector lives in one process so the ripple is a single ordered evaluation.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            {c[i+1], sum[i]} = sdb_cell(p[i], g[i], c[i]);
        end
        cout = c[WIDTH];
    end

endmodule

// File: rtl/sdb_inner.sv
// rtl/sdb_inner.sv - registered WIDTH-bit adder block; SDB_INNER_CSEL_EN selects carry-select next-state
module sdb_inner
    import sdb_pkg::*;
#(
    parameter int WIDTH = SDB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] sum_n;
    logic             carry_n;

    assign g = a & b;

`ifdef SDB_INNER_CSEL_EN
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic             c0_out;
    logic             c1_out;

    sdb_chain #(.WIDTH(WIDTH)) u_chain0 (
        .p    (p),
        .g    (g),
        .cin  (1'b0),
        .sum  (s0),
        .cout (c0_out)
    );

    sdb_chain #(.WIDTH(WIDTH)) u_chain1 (
        .p    (p),
        .g    (g),
        .cin  (1'b1),
        .sum  (s1),
        .cout (c1_out)
    );

    // Late-arriving carry-in only drives the final select, not the chains.
    assign sum_n   = c_in ? s1 : s0;
    assign carry_n = c_in ? c1_out : c0_out;
`else
    sdb_chain #(.WIDTH(WIDTH)) u_chain (
        .p    (p),
        .g    (g),
        .cin  (c_in),
        .sum  (sum_n),
        .cout (carry_n)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s     <= '0;
            c_out <= 1'b0;
        end else begin
            s     <= sum_n;
            c_out <= carry_n;
        end
    end

endmodule

// File: tb/tb_sdb_inner.sv
// tb/tb_sdb_inner.sv - scoreboard bench for sdb_inner: directed corners plus random vectors on two instances
module tb_sdb_inner;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] p = '0;
    logic         c_in = 1'b0;
    logic [W-1:0] s0, s1;
    logic         co0, co1;

    logic [W:0]   exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    sdb_inner #(.WIDTH(W)) u_dut0 (
        .clk(clk), .rst(rst), .a(a), .b(b), .p(p), .c_in(c_in), .s(s0), .c_out(co0)
    );

    sdb_inner #(.WIDTH(W)) u_dut1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .p(p), .c_in(c_in), .s(s1), .c_out(co1)
    );

    // Reference: plain addition when p is consistent, otherwise bitwise generate/propagate rules.
    function automatic logic [W:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                             input logic [W-1:0] rp, input logic rc);
        logic [W:0]   res;
        logic         carry;
        if (rp == (ra ^ rb)) begin
            res = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
        end else begin
            carry = rc;
            res   = '0;
            for (int i = 0; i < W; i++) begin
                res[i] = rp[i] ^ carry;
                carry  = (ra[i] & rb[i]) | (rp[i] & carry);
            end
            res[W] = carry;
        end
        return res;
    endfunction

    task automatic drive(input logic r, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] vp, input logic vc, input logic [W:0] expv);
        @(negedge clk);
        rst  = r;
        a    = va;
        b    = vb;
        p    = vp;
        c_in = vc;
        exp_q.push_back(r ? '0 : expv);
    endtask

    // Monitor: one result per cycle, one cycle after the inputs were presented.
    initial begin
        logic [W:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({co0, s0} !== e) begin
                    n_fail++;
                    $display("FAIL dut0 a=%h b=%h: got c_out=%b s=%h, want c_out=%b s=%h",
                             a, b, co0, s0, e[W], e[W-1:0]);
                end
                n_checks++;
                if ({co1, s1} !== e) begin
                    n_fail++;
                    $display("FAIL dut1: got c_out=%b s=%h, want c_out=%b s=%h",
                             co1, s1, e[W], e[W-1:0]);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] ra, rb, rp;
        logic         rc;
        int           wait_cycles;

        // Reset with arbitrary inputs
        for (int i = 0; i < 2; i++)
            drive(1'b1, W'($urandom), W'($urandom), W'($urandom), 1'($urandom), '0);

        // Directed corners with expectations written out by hand
        drive(1'b0, 8'h3C, 8'h5A, 8'h3C ^ 8'h5A, 1'b1, 9'h097);
        drive(1'b0, 8'hFF, 8'h01, 8'hFF ^ 8'h01, 1'b0, 9'h100);
        drive(1'b0, 8'h80, 8'h80, 8'h80 ^ 8'h80, 1'b1, 9'h101);
        drive(1'b0, 8'hFF, 8'h00, 8'hFF,         1'b1, 9'h100);
        drive(1'b0, 8'hFF, 8'h00, 8'hFF,         1'b0, 9'h0FF);
        drive(1'b0, 8'h0F, 8'h00, 8'h00,         1'b1, 9'h001);

        // Mid-stream reset on the third of five vectors
        for (int i = 1; i <= 5; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            drive(i == 3, ra, rb, ra ^ rb, rc, ref_model(ra, rb, ra ^ rb, rc));
        end

        // Random consistent-p vectors
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            drive(1'b0, ra, rb, ra ^ rb, rc, ref_model(ra, rb, ra ^ rb, rc));
        end

        // Random arbitrary-p vectors
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom); rb = W'($urandom); rp = W'($urandom); rc = 1'($urandom);
            drive(1'b0, ra, rb, rp, rc, ref_model(ra, rb, rp, rc));
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
